// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the fetch queue and its FIFO.
package cpu_pkg;

    // Canonical NOP (addi x0, x0, 0) presented to decode when nothing is valid.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Fixed instruction size; fetch advances by this many bytes per request.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // One buffered fetch result: the address it came from and the word returned.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential next fetch address; wraps modulo 2^32, low bits passed through untouched.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with a separate occupancy counter so full and empty
// are unambiguous while the power-of-two pointers wrap freely. Flush beats push/pop.
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_entry_t,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              din,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is dropped; a push while full is only allowed alongside a pop.
    assign pop_ok  = pop  && !flush && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);

    // Storage write port.
    // NOTE: the data array is deliberately not reset; occupancy and pointers define
    // which slots are meaningful, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy next-state; flush returns everything to empty.
    // NOTE: every signal assigned here gets its hold value first, so no path leaves
    // it unassigned and no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues requests to a 1-cycle-latency instruction
// memory, buffers returned {pc, instr} pairs and hands them to decode with a
// valid/ready handshake. An EX redirect flushes everything fetched or in flight.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                redirect_addr,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [31:0]                dec_instr,
    output logic [31:0]                dec_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pc_q,       pc_d;
    logic         inflight_q, inflight_d;

    logic         credit_ok;
    logic [CW:0]  outstanding;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // Entries already buffered plus the one response that may still be on its way.
    // A pop in this same cycle is not credited, which keeps the check purely registered.
    assign outstanding = {1'b0, count} + (CW+1)'(inflight_q);
    assign credit_ok   = !fifo_full && (outstanding < (CW+1)'(DEPTH));

    assign imem_req  = !reset && !redirect && credit_ok;
    assign imem_addr = fetch_pc_q;

    // A redirect kills the response arriving this cycle and any same-cycle handoff.
    assign fifo_push  = inflight_q && !redirect;
    assign fifo_pop   = dec_valid && dec_ready && !redirect;
    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    // Decode sees the FIFO head directly; no bypass from the memory return path.
    assign dec_valid = !fifo_empty;
    assign dec_instr = fifo_empty ? NOP_INSTR : head_entry.instr;
    assign dec_pc    = fifo_empty ? 32'h0     : head_entry.pc;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .din   (push_entry),
        .head  (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetch address, in-flight tag and address of the outstanding request.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inflight_d = imem_req;
        if (redirect) begin
            fetch_pc_d = redirect_addr;
        end else if (imem_req) begin
            fetch_pc_d = next_pc(fetch_pc_q);
            pc_d       = fetch_pc_q;
        end
    end

    // Fetch-side registers; reset restarts at RESET_PC and drops any in-flight response.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= 32'h0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases plus a randomized stall/redirect
// phase, all compared every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  count;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .count         (count)
    );

    always #5 clk = ~clk;

    // Reference model: queue of buffered PCs, one pending request, current fetch address.
    logic [31:0] mq[$];
    int          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fetch_pc;

    int          n_checks = 0;
    int          n_err    = 0;
    bit          last_valid;
    logic [31:0] last_pc;
    bit          seen_200;
    bit          seq_on;
    bit          have_prev;
    logic [31:0] prev_pc;
    int          pops;

    // Memory contents: a fixed scramble of the address so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then act as
    // memory by returning the word for the request sampled at this rising edge.
    task automatic tick();
        logic        e_req;
        logic        s_req;
        logic [31:0] s_addr;
        @(negedge clk);
        e_req = !reset && !redirect && ((mq.size() + m_infl) < DEPTH);
        check("imem_req",  32'(imem_req),  32'(e_req));
        check("imem_addr", imem_addr,      m_fetch_pc);
        check("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
        check("dec_pc",    dec_pc,         (mq.size() != 0) ? mq[0] : 32'h0);
        check("dec_instr", dec_instr,      (mq.size() != 0) ? mem_word(mq[0]) : NOP);
        check("count",     32'(count),     32'(mq.size()));

        last_valid = dec_valid;
        last_pc    = dec_pc;
        if (dec_valid && dec_pc >= 32'h200 && dec_pc < 32'h300) seen_200 = 1'b1;
        if (seq_on) begin
            if (redirect || reset) begin
                have_prev = 1'b0;
            end else if (dec_valid && dec_ready) begin
                if (have_prev) check("pc_seq", dec_pc, prev_pc + 32'd4);
                prev_pc   = dec_pc;
                have_prev = 1'b1;
                pops++;
            end
        end

        s_req  = imem_req;
        s_addr = imem_addr;

        if (reset) begin
            mq.delete();
            m_infl     = 0;
            m_fetch_pc = RESET_PC;
        end else if (redirect) begin
            mq.delete();
            m_infl     = 0;
            m_fetch_pc = redirect_addr;
        end else begin
            if (mq.size() != 0 && dec_ready) void'(mq.pop_front());
            if (m_infl != 0) mq.push_back(m_infl_pc);
            m_infl = e_req ? 1 : 0;
            if (e_req) begin
                m_infl_pc  = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        imem_rdata = s_req ? mem_word(s_addr) : 32'hDEAD_BEEF;
    endtask

    // Cycles after the triggering cycle until decode sees a valid entry (0 = never).
    task automatic wait_valid(input int max_cycles, output int lat);
        lat = 0;
        for (int k = 1; k <= max_cycles; k++) begin
            tick();
            if (last_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        dec_ready     = 1'b0;
        imem_rdata    = 32'h0;
        seen_200      = 1'b0;
        seq_on        = 1'b0;
        have_prev     = 1'b0;
        prev_pc       = 32'h0;
        pops          = 0;
        mq.delete();
        m_infl        = 0;
        m_infl_pc     = 32'h0;
        m_fetch_pc    = RESET_PC;
        @(posedge clk);
        #1;

        // Reset state, then streaming with decode always ready.
        tick();
        tick();
        reset     = 1'b0;
        dec_ready = 1'b1;
        wait_valid(10, lat);
        check("reset_latency", 32'(lat), 32'd3);
        check("first_pc", last_pc, RESET_PC);
        for (int i = 0; i < 20; i++) tick();
        check("steady_count", 32'(count), 32'd1);

        // Decode stall: occupancy saturates at DEPTH and requests stop.
        dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("stall_count", 32'(count), DEPTH);
        check("stall_req",   32'(imem_req), 32'd0);
        dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        // Redirect while three entries are buffered and one response is in flight.
        dec_ready = 1'b0;
        for (int k = 0; k < 20 && !(mq.size() == 3 && m_infl == 1); k++) tick();
        check("pre_redirect_count", 32'(count), 32'd3);
        redirect      = 1'b1;
        redirect_addr = 32'h100;
        dec_ready     = 1'b1;
        tick();
        redirect = 1'b0;
        #1;
        check("redir_count", 32'(count),     32'd0);
        check("redir_valid", 32'(dec_valid), 32'd0);
        check("redir_addr",  imem_addr,      32'h100);
        check("redir_req",   32'(imem_req),  32'd1);
        wait_valid(10, lat);
        check("redirect_latency", 32'(lat), 32'd3);
        check("redirect_pc", last_pc, 32'h100);
        for (int i = 0; i < 8; i++) tick();

        // Back-to-back redirects: only the second target is ever fetched.
        seen_200      = 1'b0;
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        tick();
        redirect_addr = 32'h300;
        tick();
        redirect = 1'b0;
        #1;
        check("b2b_addr", imem_addr,     32'h300);
        check("b2b_req",  32'(imem_req), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("no_stale_200", 32'(seen_200), 32'd0);

        // Random 30% stalls with occasional redirects until 1000 instructions retire.
        seq_on    = 1'b1;
        have_prev = 1'b0;
        pops      = 0;
        for (int c = 0; c < 8000 && pops < 1000; c++) begin
            dec_ready     = ($urandom_range(99) >= 30);
            redirect      = ($urandom_range(99) < 2);
            redirect_addr = 32'h0001_0000 + (32'($urandom_range(4095)) << 2)
                            + (($urandom_range(9) == 0) ? 32'd1 : 32'd0);
            tick();
        end
        redirect = 1'b0;
        seq_on   = 1'b0;
        check("random_pops_done", 32'(pops >= 1000), 32'd1);

        // Reset with the FIFO full: everything clears and fetch restarts at RESET_PC.
        dec_ready = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("full_before_reset", 32'(count), DEPTH);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_count", 32'(count),     32'd0);
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_addr",  imem_addr,      RESET_PC);
        dec_ready = 1'b1;
        wait_valid(10, lat);
        check("rst_latency", 32'(lat), 32'd3);
        check("rst_restart_pc", last_pc, RESET_PC);
        for (int i = 0; i < 10; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
